sym_strobe_ctrl: RTL and testbench
==================================

# sym_strobe_ctrl

Symbol-timing controller for the QAM-16 receiver front end. After a frame sync it generates the one-cycle `start` strobes that drive the downstream `sampling` register, one per symbol, at a programmable phase and samples-per-symbol rate. It counts symbols up to a programmed frame length, then signals frame completion. It also reports configuration errors and aborts.

## Interface
Parameters:
- `CNT_W`, 8: width of the samples-per-symbol and phase fields.
- `FRAME_W`, 10: width of the frame-length and symbol-index fields.

Ports:
- `clk`  in  1  system clock; all logic on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `enable`  in  1  level; controller may run only while high.
- `sync`  in  1  one-cycle frame-sync pulse from the preamble detector.
- `sps`  in  CNT_W  samples (clk cycles) per symbol; valid range 2..2^CNT_W-1.
- `phase`  in  CNT_W  strobe offset after sync; valid range 0..sps-1.
- `frame_len`  in  FRAME_W  symbols per frame; valid range 1..2^FRAME_W-1.
- `sample_start`  out  1  one-cycle strobe, connected to `sampling.start`.
- `sym_idx`  out  FRAME_W  index of the most recent strobe (0-based).
- `busy`  out  1  high while a frame is in progress.
- `frame_done`  out  1  one-cycle pulse when a frame completes normally.
- `aborted`  out  1  one-cycle pulse when a frame is cut short by `enable` low.
- `cfg_err`  out  1  sticky flag: the last sync was rejected for invalid config.

## Operation
- All outputs are registered.
- Reset values: `sample_start`=0, `sym_idx`=0, `busy`=0, `frame_done`=0, `aborted`=0, `cfg_err`=0. State is IDLE and all counters are 0.
- **IDLE**
  - A sync is accepted only when `sync`=1 and `enable`=1.
  - Invalid config (`sps`<2, `phase`>=`sps`, or `frame_len`=0): set `cfg_err`=1 and stay in IDLE.
  - Valid config: clear `cfg_err`, latch `sps`/`phase`/`frame_len` into shadow registers, clear the cycle counter, go to ALIGN.
  - `sync` with `enable`=0 is ignored and leaves `cfg_err` unchanged.
- **ALIGN**
  - The cycle counter increments each clock.
  - The first strobe is issued when the count reaches `phase`; `sym_idx`=0. The counter then reloads and the state goes to RUN.
- **RUN**
  - The counter counts 1..sps and wraps.
  - A strobe is issued on each wrap, and `sym_idx` increments with each strobe.
  - After the strobe with `sym_idx`=`frame_len`-1, go to DONE.
- **DONE**
  - Lasts exactly one cycle: `frame_done`=1, `busy`=0 on the next edge, then IDLE.
  - `sym_idx` holds its last value until the next accepted sync, where it is cleared.
- **Abort**
  - `enable`=0 in ALIGN or RUN: on the next edge go to IDLE, assert `aborted` for one cycle, drop `busy`.
  - No further strobes and no `frame_done`.
  - If `enable` falls in the same cycle a strobe would be issued, the abort wins and no strobe occurs.
- **Sync while busy:** ignored (no resync, no error). `sync` in the DONE cycle is also ignored.
- **Live config inputs:** changes to `sps`/`phase`/`frame_len` after acceptance have no effect until the next accepted sync.
- **Counter width:** the counter is CNT_W bits and never overflows, because the shadow `sps` is at most 2^CNT_W-1.

## Timing
- Sync accepted at edge k:
  - `busy`=1 from edge k.
  - First `sample_start` is high in the cycle following edge k+1+`phase`.
  - Strobe n (0-based) is at edge k+1+`phase`+n·`sps`.
- `frame_done` is high in the cycle after the final strobe. `busy` falls at that same edge, i.e. it is low during the `frame_done` cycle.
- A new sync is acceptable from the cycle after `frame_done`.
- `aborted` is high in the cycle after the edge that samples `enable`=0.
- `cfg_err` rises at edge k on a rejected sync. It falls at the edge of the next accepted sync, or on reset.
- Reset asserted mid-frame: all outputs clear immediately (asynchronously). No `aborted` or `frame_done` pulse.

## Test plan
1. `sps`=4, `phase`=1, `frame_len`=3, sync at edge 10:
   - strobes at edges 12, 16, 20 with `sym_idx` 0, 1, 2;
   - `frame_done` at edge 21;
   - `busy` high on edges 10–20.
2. `sps`=2, `phase`=0, `frame_len`=1:
   - a single strobe one edge after sync, `frame_done` the next edge;
   - a back-to-back sync in the cycle after `frame_done` is accepted.
3. Rejected configs:
   - `sps`=1 → `cfg_err`=1, no strobes;
   - `phase`=5 with `sps`=5 → `cfg_err`=1;
   - a following valid sync clears `cfg_err` and runs normally.
4. `sps`=8, `frame_len`=100: drop `enable` in the cycle the 4th strobe is due → no 4th strobe, `aborted` pulse, `busy`=0, `sym_idx`=2.
5. Extra syncs and live config changes during RUN (`sps`=3, `frame_len`=5):
   - extra `sync` pulses are ignored;
   - changing `sps` to 6 mid-frame does not alter the 3-cycle spacing;
   - exactly 5 strobes are issued.
6. `rst_n` low mid-RUN: outputs clear asynchronously with no pulses; after release the controller sits in IDLE until a sync arrives.

Source files
------------

// File: rtl/sym_strobe_ctrl.sv
// Symbol-timing controller: after an accepted frame sync, emits one sample_start
// strobe per symbol at a programmable phase and rate, then flags frame completion.
module sym_strobe_ctrl #(
   parameter int CNT_W   = 8,
   parameter int FRAME_W = 10
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               enable,
   input  logic               sync,
   input  logic [CNT_W-1:0]   sps,
   input  logic [CNT_W-1:0]   phase,
   input  logic [FRAME_W-1:0] frame_len,
   output logic               sample_start,
   output logic [FRAME_W-1:0] sym_idx,
   output logic               busy,
   output logic               frame_done,
   output logic               aborted,
   output logic               cfg_err
);

   typedef enum logic [1:0] {IDLE, ALIGN, RUN, DONE} state_t;

   state_t             state;
   logic [CNT_W-1:0]   cnt;
   logic [CNT_W-1:0]   sps_s;
   logic [CNT_W-1:0]   phase_s;
   logic [FRAME_W-1:0] len_s;

   logic               sync_acc;
   logic               cfg_ok;
   logic [FRAME_W-1:0] idx_nxt;
   logic               align_last;
   logic               run_last;

   assign sync_acc   = sync && enable;
   assign cfg_ok     = (sps >= CNT_W'(2)) && (phase < sps) && (frame_len != '0);
   assign idx_nxt    = sym_idx + FRAME_W'(1);
   assign align_last = (len_s == FRAME_W'(1));
   assign run_last   = (idx_nxt == len_s - FRAME_W'(1));

   // Shadow configuration is pure data: captured on an accepted sync, never reset.
   always_ff @(posedge clk) begin
      if (state == IDLE && sync_acc && cfg_ok) begin
         sps_s   <= sps;
         phase_s <= phase;
         len_s   <= frame_len;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= IDLE;
         cnt          <= '0;
         sample_start <= 1'b0;
         sym_idx      <= '0;
         busy         <= 1'b0;
         frame_done   <= 1'b0;
         aborted      <= 1'b0;
         cfg_err      <= 1'b0;
      end else begin
         sample_start <= 1'b0;
         frame_done   <= 1'b0;
         aborted      <= 1'b0;
         case (state)
            IDLE: begin
               if (sync_acc) begin
                  if (cfg_ok) begin
                     cfg_err <= 1'b0;
                     cnt     <= '0;
                     sym_idx <= '0;
                     busy    <= 1'b1;
                     state   <= ALIGN;
                  end else begin
                     cfg_err <= 1'b1;
                  end
               end
            end
            ALIGN: begin
               if (!enable) begin
                  aborted <= 1'b1;
                  busy    <= 1'b0;
                  state   <= IDLE;
               end else if (cnt == phase_s) begin
                  // Reload to 1 so the RUN count 1..sps spaces strobes exactly sps apart.
                  sample_start <= 1'b1;
                  sym_idx      <= '0;
                  cnt          <= CNT_W'(1);
                  state        <= align_last ? DONE : RUN;
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            RUN: begin
               if (!enable) begin
                  aborted <= 1'b1;
                  busy    <= 1'b0;
                  state   <= IDLE;
               end else if (cnt == sps_s) begin
                  sample_start <= 1'b1;
                  sym_idx      <= idx_nxt;
                  cnt          <= CNT_W'(1);
                  if (run_last) state <= DONE;
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            DONE: begin
               frame_done <= 1'b1;
               busy       <= 1'b0;
               state      <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_sym_strobe_ctrl.sv
// Scoreboard bench for sym_strobe_ctrl: stimulus queues expected pulses,
// a negedge monitor pops and compares each pulse the controller emits.
module tb_sym_strobe_ctrl;
   localparam int CNT_W   = 8;
   localparam int FRAME_W = 10;

   logic               clk = 1'b0;
   logic               rst_n = 1'b0;
   logic               enable = 1'b0;
   logic               sync = 1'b0;
   logic [CNT_W-1:0]   sps = '0;
   logic [CNT_W-1:0]   phase = '0;
   logic [FRAME_W-1:0] frame_len = '0;
   logic               sample_start;
   logic [FRAME_W-1:0] sym_idx;
   logic               busy;
   logic               frame_done;
   logic               aborted;
   logic               cfg_err;

   sym_strobe_ctrl #(.CNT_W(CNT_W), .FRAME_W(FRAME_W)) dut (
      .clk(clk), .rst_n(rst_n), .enable(enable), .sync(sync),
      .sps(sps), .phase(phase), .frame_len(frame_len),
      .sample_start(sample_start), .sym_idx(sym_idx), .busy(busy),
      .frame_done(frame_done), .aborted(aborted), .cfg_err(cfg_err)
   );

   always #5 clk = ~clk;

   int edge_no = 0;
   always @(posedge clk) edge_no <= edge_no + 1;

   // kind: 0 strobe, 1 frame_done, 2 aborted
   typedef struct {
      int kind;
      int edge_n;
      int idx;
   } ev_t;

   ev_t exp_q[$];
   int  checks = 0;
   int  failures = 0;

   task automatic chk(input string name, input int act, input int req);
      checks++;
      if (act != req) begin
         failures++;
         $display("FAIL %s at edge %0d: got %0d expected %0d", name, edge_no, act, req);
      end
   endtask

   function automatic void push_ev(input int kind, input int e, input int idx);
      ev_t ev;
      ev.kind   = kind;
      ev.edge_n = e;
      ev.idx    = idx;
      exp_q.push_back(ev);
   endfunction

   // Strobe n at k+1+phase+n*sps, frame_done one edge after the last strobe.
   function automatic void push_frame(input int k, input int ph, input int sp, input int len);
      for (int n = 0; n < len; n++) push_ev(0, k + 1 + ph + n * sp, n);
      push_ev(1, k + 1 + ph + (len - 1) * sp + 1, -1);
   endfunction

   task automatic mon_ev(input int kind, input int idx);
      ev_t ev;
      if (exp_q.size() == 0) begin
         checks++;
         failures++;
         $display("FAIL unexpected_pulse at edge %0d: got kind %0d expected none", edge_no, kind);
      end else begin
         ev = exp_q.pop_front();
         chk("event_kind", kind, ev.kind);
         chk("event_edge", edge_no, ev.edge_n);
         if (kind == 0 && ev.kind == 0) chk("strobe_sym_idx", idx, ev.idx);
      end
   endtask

   always @(negedge clk) begin
      if (sample_start) mon_ev(0, int'(sym_idx));
      if (frame_done)   mon_ev(1, -1);
      if (aborted)      mon_ev(2, -1);
   end

   task automatic wait_edge(input int e);
      while (edge_no < e) @(negedge clk);
   endtask

   task automatic wait_cycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Called at a negedge; the sync is sampled by the next rising edge, returned as k.
   task automatic do_sync(output int k);
      sync = 1'b1;
      k = edge_no + 1;
      @(negedge clk);
      sync = 1'b0;
   endtask

   task automatic set_cfg(input int s, input int p, input int l);
      sps       = CNT_W'(s);
      phase     = CNT_W'(p);
      frame_len = FRAME_W'(l);
   endtask

   int k, k2, dummy;

   initial begin
      @(negedge clk);
      chk("rst_sample_start", int'(sample_start), 0);
      chk("rst_sym_idx", int'(sym_idx), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_frame_done", int'(frame_done), 0);
      chk("rst_aborted", int'(aborted), 0);
      chk("rst_cfg_err", int'(cfg_err), 0);
      wait_cycles(2);
      rst_n  = 1'b1;
      enable = 1'b1;

      // Test 1: sps=4 phase=1 len=3, sync at edge 10
      set_cfg(4, 1, 3);
      wait_edge(9);
      do_sync(k);
      push_ev(0, 12, 0);
      push_ev(0, 16, 1);
      push_ev(0, 20, 2);
      push_ev(1, 21, -1);
      chk("t1_busy_at_10", int'(busy), 1);
      wait_edge(20);
      chk("t1_busy_at_20", int'(busy), 1);
      wait_edge(21);
      chk("t1_busy_at_21", int'(busy), 0);
      chk("t1_sym_idx_hold", int'(sym_idx), 2);
      wait_cycles(3);

      // Test 2: single-symbol frame, then back-to-back sync in the frame_done cycle
      set_cfg(2, 0, 1);
      do_sync(k);
      push_frame(k, 0, 2, 1);
      wait_edge(k + 2);
      chk("t2_done_cycle_busy", int'(busy), 0);
      do_sync(k2);
      push_frame(k2, 0, 2, 1);
      chk("t2_resync_busy", int'(busy), 1);
      wait_edge(k2 + 4);

      // Test 3: rejected configurations
      set_cfg(1, 0, 3);
      do_sync(k);
      chk("t3_sps1_cfg_err", int'(cfg_err), 1);
      chk("t3_sps1_busy", int'(busy), 0);
      wait_cycles(6);
      set_cfg(3, 2, 2);
      enable = 1'b0;
      do_sync(k);
      chk("t3_disabled_sync_cfg_err", int'(cfg_err), 1);
      chk("t3_disabled_sync_busy", int'(busy), 0);
      enable = 1'b1;
      wait_cycles(2);
      do_sync(k);
      push_frame(k, 2, 3, 2);
      chk("t3_valid_clears_cfg_err", int'(cfg_err), 0);
      wait_edge(k + 10);
      set_cfg(5, 5, 3);
      do_sync(k);
      chk("t3_phase_eq_sps_cfg_err", int'(cfg_err), 1);
      wait_cycles(6);
      set_cfg(6, 5, 1);
      do_sync(k);
      push_frame(k, 5, 6, 1);
      chk("t3_valid2_clears_cfg_err", int'(cfg_err), 0);
      wait_edge(k + 10);

      // Test 4: abort on the cycle the 4th strobe is due
      set_cfg(8, 0, 100);
      do_sync(k);
      push_ev(0, k + 1, 0);
      push_ev(0, k + 9, 1);
      push_ev(0, k + 17, 2);
      push_ev(2, k + 25, -1);
      wait_edge(k + 24);
      enable = 1'b0;
      @(negedge clk);
      chk("t4_abort_busy", int'(busy), 0);
      chk("t4_abort_sym_idx", int'(sym_idx), 2);
      enable = 1'b1;
      wait_cycles(12);

      // Test 5: extra syncs and live config changes mid-frame
      set_cfg(3, 1, 5);
      do_sync(k);
      push_frame(k, 1, 3, 5);
      wait_edge(k + 3);
      do_sync(dummy);
      set_cfg(6, 4, 9);
      chk("t5_extra_sync_busy", int'(busy), 1);
      chk("t5_extra_sync_cfg_err", int'(cfg_err), 0);
      wait_edge(k + 8);
      do_sync(dummy);
      wait_edge(k + 15);
      chk("t5_done_busy", int'(busy), 0);
      chk("t5_final_sym_idx", int'(sym_idx), 4);
      wait_cycles(8);

      // Test 6: reset asserted during a strobe cycle mid-frame
      set_cfg(4, 0, 50);
      do_sync(k);
      push_ev(0, k + 1, 0);
      push_ev(0, k + 5, 1);
      wait_edge(k + 5);
      #2 rst_n = 1'b0;
      #1;
      chk("t6_rst_sample_start", int'(sample_start), 0);
      chk("t6_rst_busy", int'(busy), 0);
      chk("t6_rst_sym_idx", int'(sym_idx), 0);
      wait_cycles(3);
      rst_n = 1'b1;
      wait_cycles(20);
      chk("t6_idle_busy", int'(busy), 0);
      set_cfg(2, 1, 2);
      do_sync(k);
      push_frame(k, 1, 2, 2);
      wait_edge(k + 8);

      chk("queue_drained", exp_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
